// File: rtl/result_drain_pkg.sv
// ============================================================================
// result_drain_pkg : shared types, sizes and lane helper for the result drain
// Revision: 1.0
// ============================================================================
`default_nettype none

package result_drain_pkg;

  localparam int COLS  = 32;
  localparam int AW    = 5;
  localparam int DW    = 256;
  localparam int OW    = 32;
  localparam int LANES = DW / OW;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  // Lane 0 sits in the most significant word of a column.
  function automatic logic [OW-1:0] lane_sel(input logic [DW-1:0] col,
                                              input logic [2:0]    lane);
    lane_sel = col[DW-1-OW*int'(lane) -: OW];
  endfunction

endpackage

`default_nettype wire

// File: rtl/result_buf.sv
// ============================================================================
// result_buf : COLS x DW register array, one write port, async read port
// Revision: 1.0
// ============================================================================
`default_nettype none

module result_buf
  import result_drain_pkg::*;
(
  input  logic          CLK,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  // Contents are intentionally not reset.
  logic [DW-1:0] mem_q [COLS];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/result_drain.sv
// ============================================================================
// result_drain : collects 32 column results, then streams them as 32-bit words
// Revision: 1.0
// ============================================================================
`default_nettype none

module result_drain
  import result_drain_pkg::*;
(
  input  logic          CLK,
  input  logic          RESET,
  input  logic          ans_valid,
  input  logic [AW-1:0] result_addr,
  input  logic [DW-1:0] result_data,
  input  logic          clear,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [OW-1:0] m_data,
  output logic [AW-1:0] m_col,
  output logic [2:0]    m_lane,
  output logic          m_last,
  output logic          done,
  output logic [AW:0]   cap_count,
  output logic          dup_err,
  output logic          ovf_err
);

  localparam logic [AW:0]   FULL_COUNT = (AW+1)'(COLS);
  localparam logic [AW-1:0] LAST_COL   = AW'(COLS - 1);
  localparam logic [2:0]    LAST_LANE  = 3'(LANES - 1);

  state_t          state_q, state_d;
  logic            ans_valid_q;
  logic [COLS-1:0] vld_q, vld_d;
  logic [AW:0]     cap_count_q, cap_count_d;
  logic            dup_err_q, dup_err_d;
  logic            ovf_err_q, ovf_err_d;
  logic [AW-1:0]   m_col_q, m_col_d;
  logic [2:0]      m_lane_q, m_lane_d;

  logic            cap;
  logic            accept;
  logic            hs;
  logic [DW-1:0]   rd_col;

  result_buf u_buf (
    .CLK   (CLK),
    .we    (accept),
    .waddr (result_addr),
    .wdata (result_data),
    .raddr (m_col_q),
    .rdata (rd_col)
  );

  always_comb begin
    state_d     = state_q;
    vld_d       = vld_q;
    cap_count_d = cap_count_q;
    dup_err_d   = dup_err_q;
    ovf_err_d   = ovf_err_q;
    m_col_d     = m_col_q;
    m_lane_d    = m_lane_q;

    // Rising edge only: a long ans_valid level is a single capture.
    cap     = ans_valid & ~ans_valid_q;
    accept  = cap & ((state_q == IDLE) | (state_q == COLLECT));
    m_valid = (state_q == DRAIN);
    m_last  = m_valid & (m_col_q == LAST_COL) & (m_lane_q == LAST_LANE);
    hs      = m_valid & m_ready;

    if (accept) begin
      if (vld_q[result_addr]) begin
        dup_err_d = 1'b1;
      end else begin
        vld_d[result_addr] = 1'b1;
        cap_count_d        = cap_count_q + 1'b1;
      end
    end
    if (cap & ~accept) begin
      ovf_err_d = 1'b1;
    end

    // Column/lane wrap back to zero naturally after the final word.
    if (hs) begin
      m_lane_d = m_lane_q + 3'd1;
      if (m_lane_q == LAST_LANE) begin
        m_col_d = m_col_q + 1'b1;
      end
    end

    case (state_q)
      IDLE:    if (accept) state_d = COLLECT;
      COLLECT: if (cap_count_q == FULL_COUNT) state_d = DRAIN;
      DRAIN:   if (hs & m_last) state_d = DONE;
      DONE: begin
        if (clear) begin
          state_d     = IDLE;
          vld_d       = '0;
          cap_count_d = '0;
          dup_err_d   = 1'b0;
          ovf_err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q     <= IDLE;
      ans_valid_q <= 1'b0;
      vld_q       <= '0;
      cap_count_q <= '0;
      dup_err_q   <= 1'b0;
      ovf_err_q   <= 1'b0;
      m_col_q     <= '0;
      m_lane_q    <= '0;
    end else begin
      state_q     <= state_d;
      ans_valid_q <= ans_valid;
      vld_q       <= vld_d;
      cap_count_q <= cap_count_d;
      dup_err_q   <= dup_err_d;
      ovf_err_q   <= ovf_err_d;
      m_col_q     <= m_col_d;
      m_lane_q    <= m_lane_d;
    end
  end

  assign m_data    = lane_sel(rd_col, m_lane_q);
  assign m_col     = m_col_q;
  assign m_lane    = m_lane_q;
  assign done      = (state_q == DONE);
  assign cap_count = cap_count_q;
  assign dup_err   = dup_err_q;
  assign ovf_err   = ovf_err_q;

endmodule

`default_nettype wire

// File: tb/tb_result_drain.sv
// ============================================================================
// tb_result_drain : randomized jobs checked every cycle against a word-level model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_result_drain;

  logic         CLK = 1'b0;
  logic         RESET = 1'b0;
  logic         ans_valid = 1'b0;
  logic [4:0]   result_addr = '0;
  logic [255:0] result_data = '0;
  logic         clear = 1'b0;
  logic         m_ready = 1'b0;
  logic         m_valid;
  logic [31:0]  m_data;
  logic [4:0]   m_col;
  logic [2:0]   m_lane;
  logic         m_last;
  logic         done;
  logic [5:0]   cap_count;
  logic         dup_err;
  logic         ovf_err;

  result_drain dut (
    .CLK(CLK), .RESET(RESET), .ans_valid(ans_valid), .result_addr(result_addr),
    .result_data(result_data), .clear(clear), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_col(m_col), .m_lane(m_lane), .m_last(m_last), .done(done),
    .cap_count(cap_count), .dup_err(dup_err), .ovf_err(ovf_err)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  // Reference model: phase 0 idle, 1 collecting, 2 draining, 3 done.
  int          ph = 0;
  bit          mvld [32];
  int          mcount = 0;
  bit          mdup = 0;
  bit          movf = 0;
  int          mword = 0;
  logic [31:0] mbuf [32][8];
  bit          prev_av = 0;
  bit          checking = 0;
  int          rmode = 0;

  always @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      ph = 0; mcount = 0; mdup = 0; movf = 0; mword = 0; prev_av = 0;
      for (int i = 0; i < 32; i++) mvld[i] = 0;
    end else begin : upd
      bit cap, hs;
      int cnt_pre;
      cap     = ans_valid && !prev_av;
      prev_av = ans_valid;
      hs      = (ph == 2) && m_ready;
      cnt_pre = mcount;
      if (cap) begin
        if (ph <= 1) begin
          for (int k = 0; k < 8; k++) mbuf[result_addr][k] = result_data[255-32*k -: 32];
          if (mvld[result_addr]) mdup = 1;
          else begin mvld[result_addr] = 1; mcount++; end
        end else begin
          movf = 1;
        end
      end
      case (ph)
        0: if (cap) ph = 1;
        1: if (cnt_pre == 32) ph = 2;
        2: if (hs) begin
             if (mword == 255) ph = 3;
             mword = (mword + 1) % 256;
           end
        3: if (clear) begin
             ph = 0; mcount = 0; mdup = 0; movf = 0;
             for (int i = 0; i < 32; i++) mvld[i] = 0;
           end
        default: ph = 0;
      endcase
    end
  end

  // Handshake monitor used for literal pins on the first/last word and word count.
  int          dut_hs = 0;
  logic [31:0] first_w = '0;
  logic [31:0] last_w  = '0;
  always @(posedge CLK) begin
    if (RESET && m_valid && m_ready) begin
      if (m_col == 5'd0 && m_lane == 3'd0) first_w = m_data;
      if (m_last) last_w = m_data;
      dut_hs++;
    end
  end

  always @(negedge CLK) begin
    if (checking && RESET) begin : cmp
      logic [50:0] got, exp;
      bit ev;
      ev  = (ph == 2);
      exp = {ev, ev && (mword == 255), ph == 3, mdup, movf, 6'(mcount),
             5'(mword / 8), 3'(mword % 8), ev ? mbuf[mword/8][mword%8] : 32'h0};
      got = {m_valid, m_last, done, dup_err, ovf_err, cap_count, m_col, m_lane,
             m_valid ? m_data : 32'h0};
      total++;
      if (got !== exp) begin
        bad++;
        $display("FAIL cycle_cmp t=%0t: got %h want %h", $time, got, exp);
      end
    end
  end

  initial begin : rdy
    int cyc;
    cyc = 0;
    forever begin
      @(posedge CLK); #1;
      cyc++;
      case (rmode)
        0: m_ready = 1'b1;
        1: m_ready = cyc[0];
        2: m_ready = 1'($urandom_range(0, 1));
        default: m_ready = 1'b0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic capture(input logic [4:0] a, input logic [255:0] d, input int hold);
    result_addr = a; result_data = d; ans_valid = 1'b1;
    tick(hold);
    ans_valid = 1'b0;
    tick(1);
  endtask

  task automatic wait_done(input int max);
    int n;
    n = 0;
    while (!done && n < max) begin @(negedge CLK); n++; end
    total++;
    if (!done) begin bad++; $display("FAIL wait_done: got done=0 want 1 after %0d cycles", max); end
    tick(1);
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(1); clear = 1'b0; tick(1);
  endtask

  function automatic logic [255:0] pat(input int c);
    logic [255:0] d;
    for (int k = 0; k < 8; k++) d[255-32*k -: 32] = {8'(c), 8'(k), 16'hA5A5};
    return d;
  endfunction

  function automatic logic [255:0] rnd256();
    logic [255:0] d;
    for (int i = 0; i < 8; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  int perm [32];
  int rest [30];
  int base;
  logic [255:0] d2;

  initial begin
    repeat (3) @(posedge CLK); #1;
    chk("rst_valid", m_valid, 0); chk("rst_done", done, 0);
    chk("rst_count", cap_count, 0); chk("rst_colane", {m_col, m_lane}, 0);
    chk("rst_err", {dup_err, ovf_err, m_last}, 0);
    RESET = 1'b1; checking = 1; tick(1);

    // Job A: in-order, known pattern, continuous ready.
    rmode = 0; base = dut_hs;
    for (int c = 0; c < 32; c++) capture(5'(c), pat(c), 3);
    wait_done(600);
    chk("a_words", dut_hs - base, 256);
    chk("a_first", first_w, 32'h0000A5A5);
    chk("a_last", last_w, 32'h1F07A5A5);
    chk("a_errs", {dup_err, ovf_err}, 0);
    do_clear();
    chk("a_clr_count", cap_count, 0); chk("a_clr_done", done, 0);

    // Job B: random order and data, ready low on alternate cycles.
    rmode = 1; base = dut_hs;
    for (int i = 0; i < 32; i++) perm[i] = i;
    for (int i = 31; i > 0; i--) begin : shuf
      int j, t;
      j = $urandom_range(0, i); t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 32; i++) capture(5'(perm[i]), rnd256(), $urandom_range(1, 4));
    wait_done(1200);
    chk("b_words", dut_hs - base, 256);
    do_clear();

    // Job C: duplicate on column 5, overflow and ignored clear during drain.
    rmode = 2;
    capture(5'd5, rnd256(), 2);
    capture(5'd0, rnd256(), 2);
    d2 = rnd256();
    capture(5'd5, d2, 2);
    chk("c_dup", dup_err, 1); chk("c_count2", cap_count, 2);
    chk("c_model_col5", mbuf[5][0], d2[255:224]);
    begin : fill
      int n;
      n = 0;
      for (int c = 1; c < 32; c++) if (c != 5) begin rest[n] = c; n++; end
    end
    for (int i = 29; i > 0; i--) begin : shuf2
      int j, t;
      j = $urandom_range(0, i); t = rest[i]; rest[i] = rest[j]; rest[j] = t;
    end
    for (int i = 0; i < 29; i++) capture(5'(rest[i]), rnd256(), $urandom_range(1, 3));
    tick(3);
    chk("c_count31", cap_count, 31); chk("c_nodrain", m_valid, 0);
    capture(5'(rest[29]), rnd256(), 1);
    begin : wv
      int n;
      n = 0;
      while (!m_valid && n < 50) begin @(negedge CLK); n++; end
    end
    chk("c_drain", m_valid, 1);
    tick(10);
    capture(5'd7, rnd256(), 2);
    clear = 1'b1; tick(1); clear = 1'b0; tick(1);
    chk("c_ovf", ovf_err, 1); chk("c_clr_ignored", m_valid, 1);
    wait_done(1500);
    chk("c_errs_held", {dup_err, ovf_err}, 2'b11);
    do_clear();
    chk("c_clr", {dup_err, ovf_err, cap_count}, 0);

    // Job D: long level hold, then asynchronous reset mid-drain.
    rmode = 0;
    capture(5'd3, rnd256(), 20);
    chk("d_hold_count", cap_count, 1); chk("d_hold_dup", dup_err, 0);
    for (int c = 0; c < 32; c++) if (c != 3) capture(5'(c), rnd256(), 1);
    begin : w100
      int n;
      n = 0;
      while (!(ph == 2 && mword == 100) && n < 400) begin @(negedge CLK); n++; end
    end
    chk("d_word100", mword, 100);
    #2 RESET = 1'b0;
    #1;
    chk("d_rst_out", {m_valid, m_last, done, dup_err, ovf_err}, 0);
    chk("d_rst_pos", {cap_count, m_col, m_lane}, 0);
    repeat (2) @(posedge CLK); #1;
    RESET = 1'b1; tick(1);

    // Job E: fresh job after reset drains from column 0 lane 0.
    rmode = 2; base = dut_hs;
    for (int c = 0; c < 32; c++) capture(5'(c), rnd256(), $urandom_range(1, 3));
    wait_done(1500);
    chk("e_words", dut_hs - base, 256);
    do_clear();
    chk("e_idle", {done, m_valid, cap_count}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
